// File: rtl/enemy_chase_ctrl_pkg.sv
// Shared types and helpers for the enemy movement controller.
// Used by every build, including the one with ENEMY_FLEE_EN defined.
package enemy_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        CHASE = 2'd0,
        FLEE  = 2'd1,
        DEAD  = 2'd2
    } state_t;

    localparam int FIXED_POINT_MULTIPLIER = 64;

    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'd2);
    endfunction

    // Signed division truncates toward zero, which matches the pixel convention.
    function automatic logic signed [10:0] fixed_to_pixel(input logic signed [31:0] p);
        logic signed [31:0] q;
        q = p / FIXED_POINT_MULTIPLIER;
        return q[10:0];
    endfunction

endpackage

// File: rtl/enemy_chase_ctrl_if.sv
// Frame-rate control bus between the playfield logic and one enemy controller.
interface enemy_chase_ctrl_if;
    logic               startOfFrame;
    logic        [3:0]  free_direction;
    logic        [10:0] player_x;
    logic        [10:0] player_y;
    logic               enemy_hit;
    logic               player_died;
    logic               flee_req;
    logic               alive;
    logic               fleeing;
    logic        [1:0]  direction;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;

    modport master (
        output startOfFrame, free_direction, player_x, player_y,
               enemy_hit, player_died, flee_req,
        input  alive, fleeing, direction, topLeftX, topLeftY
    );

    modport slave (
        input  startOfFrame, free_direction, player_x, player_y,
               enemy_hit, player_died, flee_req,
        output alive, fleeing, direction, topLeftX, topLeftY
    );
endinterface

// File: rtl/enemy_dir_select.sv
// Combinational heading chooser: corridor following plus chase/flee steering at junctions.
module enemy_dir_select
    import enemy_pkg::*;
(
    input  logic [3:0]  free_direction,
    input  dir_t        heading,
    input  logic [10:0] enemy_x,
    input  logic [10:0] enemy_y,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    input  logic        flee,
    output dir_t        next_dir,
    output logic        move_en
);

    // Lowest index wins: up, right, down, left.
    function automatic dir_t first_open(input logic [3:0] mask);
        dir_t r;
        r = DIR_UP;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) r = dir_t'(2'(i));
        end
        return r;
    endfunction

    logic [3:0] open_dir;
    logic [2:0] open_cnt;
    logic [5:0] ebx, eby, pbx, pby, dx, dy;
    dir_t       tgt_x, tgt_y, prim, sec;

    // Re-index so that open_dir[d] matches dir_t encoding d.
    assign open_dir = {free_direction[0], free_direction[1], free_direction[2], free_direction[3]};
    assign open_cnt = 3'(free_direction[0]) + 3'(free_direction[1])
                    + 3'(free_direction[2]) + 3'(free_direction[3]);

    assign ebx = enemy_x[10:5];
    assign eby = enemy_y[10:5];
    assign pbx = player_x[10:5];
    assign pby = player_y[10:5];
    assign dx  = (pbx >= ebx) ? (pbx - ebx) : (ebx - pbx);
    assign dy  = (pby >= eby) ? (pby - eby) : (eby - pby);

    // Equal block coordinates favour right/down when chasing, left/up when fleeing.
    assign tgt_x = ((pbx >= ebx) ^ flee) ? DIR_RIGHT : DIR_LEFT;
    assign tgt_y = ((pby >= eby) ^ flee) ? DIR_DOWN  : DIR_UP;
    assign prim  = (dx >= dy) ? tgt_x : tgt_y;
    assign sec   = (dx >= dy) ? tgt_y : tgt_x;

    always_comb begin
        next_dir = heading;
        move_en  = 1'b1;
        case (open_cnt)
            3'd0: move_en = 1'b0;
            3'd1: next_dir = first_open(open_dir);
            3'd2: begin
                if (!open_dir[heading]) begin
                    next_dir = first_open(open_dir & ~(4'd1 << reverse_dir(heading)));
                end
            end
            default: begin
                if (open_dir[prim])     next_dir = prim;
                else if (open_dir[sec]) next_dir = sec;
                else                    next_dir = first_open(open_dir);
            end
        endcase
    end

endmodule

// File: rtl/enemy_chase_ctrl.sv
// Per-enemy movement controller: heading, fixed-point position, death and respawn.
// Define ENEMY_FLEE_EN to build the FLEE state with reversal and half-speed moves.
module enemy_chase_ctrl
    import enemy_pkg::*;
#(
    parameter int INITIAL_X      = 504,
    parameter int INITIAL_Y      = 344,
    parameter int SPEED          = 128,
    parameter int RESPAWN_FRAMES = 256
) (
    input logic clk,
    input logic resetN,
    enemy_chase_ctrl_if.slave bus
);

    localparam logic signed [31:0] SpawnX      = 32'(INITIAL_X * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] SpawnY      = 32'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
    localparam logic        [10:0] RespawnLast = 11'(RESPAWN_FRAMES - 1);

    state_t             state_q, state_d;
    dir_t               dir_q, dir_d;
    logic signed [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic        [10:0] cnt_q, cnt_d;

    logic               flee_req;
    logic               flee_mode;
    logic signed [31:0] step;
    logic signed [10:0] pix_x, pix_y;
    dir_t               sel_dir;
    logic               sel_move;

`ifdef ENEMY_FLEE_EN
    assign flee_req    = bus.flee_req;
    assign bus.fleeing = (state_q == FLEE);
`else
    assign flee_req    = 1'b0;
    assign bus.fleeing = 1'b0;
`endif

    // Steering and speed follow the mode the enemy is in after this frame.
    assign flee_mode = (state_q == FLEE) && flee_req;
    assign step      = flee_mode ? 32'(SPEED / 2) : 32'(SPEED);
    assign pix_x     = fixed_to_pixel(pos_x_q);
    assign pix_y     = fixed_to_pixel(pos_y_q);

    enemy_dir_select u_dir_select (
        .free_direction (bus.free_direction),
        .heading        (dir_q),
        .enemy_x        (pix_x),
        .enemy_y        (pix_y),
        .player_x       (bus.player_x),
        .player_y       (bus.player_y),
        .flee           (flee_mode),
        .next_dir       (sel_dir),
        .move_en        (sel_move)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= CHASE;
            dir_q   <= DIR_LEFT;
            pos_x_q <= SpawnX;
            pos_y_q <= SpawnY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        cnt_d   = cnt_q;

        if (state_q != DEAD && (bus.enemy_hit || bus.player_died)) begin
            state_d = DEAD;
            cnt_d   = '0;
        end else if (bus.startOfFrame) begin
            if (state_q == DEAD) begin
                if (cnt_q == RespawnLast) begin
                    state_d = flee_req ? FLEE : CHASE;
                    dir_d   = DIR_LEFT;
                    pos_x_d = SpawnX;
                    pos_y_d = SpawnY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end else if (state_q == CHASE && flee_req) begin
                state_d = FLEE;
                dir_d   = reverse_dir(dir_q);
            end else begin
                state_d = flee_req ? FLEE : CHASE;
                if (sel_move) begin
                    dir_d = sel_dir;
                    unique case (sel_dir)
                        DIR_UP:    pos_y_d = pos_y_q - step;
                        DIR_RIGHT: pos_x_d = pos_x_q + step;
                        DIR_DOWN:  pos_y_d = pos_y_q + step;
                        DIR_LEFT:  pos_x_d = pos_x_q - step;
                    endcase
                end
            end
        end
    end

    assign bus.alive     = (state_q != DEAD);
    assign bus.direction = dir_q;
    assign bus.topLeftX  = pix_x;
    assign bus.topLeftY  = pix_y;

endmodule

// File: tb/tb_enemy_chase_ctrl.sv
// Directed and randomized check of enemy_chase_ctrl against a frame-level reference model.
module tb_enemy_chase_ctrl;

`ifdef ENEMY_FLEE_EN
    localparam bit FleeEn = 1'b1;
`else
    localparam bit FleeEn = 1'b0;
`endif
    localparam int RespawnFrames = 4;
    localparam int Speed         = 128;

    logic clk;
    logic resetN;
    enemy_chase_ctrl_if bus ();

    enemy_chase_ctrl #(
        .INITIAL_X      (504),
        .INITIAL_Y      (344),
        .SPEED          (Speed),
        .RESPAWN_FRAMES (RespawnFrames)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fixed-point position, heading 0..3 (up,right,down,left).
    int m_x, m_y, m_dir, m_cnt;
    bit m_dead, m_flee;

    function automatic bit is_open(input logic [3:0] f, input int d);
        return f[3 - d];
    endfunction

    function automatic int first_open(input logic [3:0] f, input int excl);
        for (int d = 0; d < 4; d++) if (is_open(f, d) && d != excl) return d;
        return -1;
    endfunction

    function automatic int pix(input int fp);
        return (fp / 64) & 32'h7ff;
    endfunction

    function automatic int choose(input logic [3:0] f, input int h, input int ex, input int ey,
                                  input int px, input int py, input bit flee);
        int s, ebx, eby, pbx, pby, dx, dy, tx, ty, prim, sec;
        s = f[0] + f[1] + f[2] + f[3];
        if (s == 0) return -1;
        if (s == 1) return first_open(f, -1);
        if (s == 2) return is_open(f, h) ? h : first_open(f, (h + 2) % 4);
        ebx = ex / 32; eby = ey / 32; pbx = px / 32; pby = py / 32;
        dx = (pbx > ebx) ? pbx - ebx : ebx - pbx;
        dy = (pby > eby) ? pby - eby : eby - pby;
        if (!flee) begin
            tx = (pbx >= ebx) ? 1 : 3;
            ty = (pby >= eby) ? 2 : 0;
        end else begin
            tx = (pbx < ebx) ? 1 : 3;
            ty = (pby < eby) ? 2 : 0;
        end
        prim = (dx >= dy) ? tx : ty;
        sec  = (dx >= dy) ? ty : tx;
        if (is_open(f, prim)) return prim;
        if (is_open(f, sec)) return sec;
        return first_open(f, -1);
    endfunction

    task automatic model_reset();
        m_x = 504 * 64; m_y = 344 * 64; m_dir = 3; m_cnt = 0; m_dead = 0; m_flee = 0;
    endtask

    task automatic model_update(input bit sof, input logic [3:0] fd, input int px, input int py,
                                input bit hit, input bit died, input bit flee);
        int d, stp;
        bit fr;
        fr = FleeEn && flee;
        if (!m_dead && (hit || died)) begin
            m_dead = 1; m_cnt = 0;
        end else if (sof) begin
            if (m_dead) begin
                if (m_cnt == RespawnFrames - 1) begin
                    m_dead = 0; m_flee = fr; m_cnt = 0;
                    m_x = 504 * 64; m_y = 344 * 64; m_dir = 3;
                end else m_cnt++;
            end else if (!m_flee && fr) begin
                m_flee = 1;
                m_dir  = (m_dir + 2) % 4;
            end else begin
                m_flee = fr;
                d = choose(fd, m_dir, pix(m_x), pix(m_y), px, py, m_flee);
                if (d >= 0) begin
                    stp = m_flee ? Speed / 2 : Speed;
                    m_dir = d;
                    case (d)
                        0: m_y -= stp;
                        1: m_x += stp;
                        2: m_y += stp;
                        default: m_x -= stp;
                    endcase
                end
            end
        end
    endtask

    task automatic compare_all();
        check("alive", 32'(bus.alive), 32'(!m_dead));
        check("fleeing", 32'(bus.fleeing), 32'(m_flee && !m_dead));
        check("direction", 32'(bus.direction), 32'(m_dir));
        check("topLeftX", {21'd0, bus.topLeftX}, 32'(pix(m_x)));
        check("topLeftY", {21'd0, bus.topLeftY}, 32'(pix(m_y)));
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic step(input bit sof, input logic [3:0] fd, input logic [10:0] px,
                        input logic [10:0] py, input bit hit, input bit died, input bit flee);
        bus.startOfFrame   = sof;
        bus.free_direction = fd;
        bus.player_x       = px;
        bus.player_y       = py;
        bus.enemy_hit      = hit;
        bus.player_died    = died;
        bus.flee_req       = flee;
        model_update(sof, fd, int'(px), int'(py), hit, died, flee);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        bus.startOfFrame = 0; bus.enemy_hit = 0; bus.player_died = 0;
        #2 resetN = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0;
        bus.startOfFrame = 0; bus.free_direction = 0; bus.player_x = 0; bus.player_y = 0;
        bus.enemy_hit = 0; bus.player_died = 0; bus.flee_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_x", {21'd0, bus.topLeftX}, 504);
        check("rst_y", {21'd0, bus.topLeftY}, 344);
        check("rst_dir", 32'(bus.direction), 3);
        check("rst_alive", 32'(bus.alive), 1);
        check("rst_fleeing", 32'(bus.fleeing), 0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // Corridor following.
        step(1, 4'b0001, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 0, 0, 0, 0, 0);
        check("left2_x", {21'd0, bus.topLeftX}, 500);
        step(1, 4'b0100, 0, 0, 0, 0, 0);
        check("single_dir", 32'(bus.direction), 1);
        check("single_x", {21'd0, bus.topLeftX}, 502);
        step(0, 4'b1111, 0, 0, 0, 0, 0);
        check("no_sof_x", {21'd0, bus.topLeftX}, 502);
        step(1, 4'b0101, 0, 0, 0, 0, 0);
        check("keep_x", {21'd0, bus.topLeftX}, 504);
        step(1, 4'b1010, 0, 0, 0, 0, 0);
        check("turn_dir", 32'(bus.direction), 0);
        check("turn_x", {21'd0, bus.topLeftX}, 504);
        check("turn_y", {21'd0, bus.topLeftY}, 342);

        // Junction steering toward the player.
        step(1, 4'b1111, 600, 344, 0, 0, 0);
        check("junc_dir", 32'(bus.direction), 1);
        check("junc_x", {21'd0, bus.topLeftX}, 506);
        step(1, 4'b1111, 600, 344, 0, 0, 1);
`ifdef ENEMY_FLEE_EN
        check("rev_dir", 32'(bus.direction), 3);
        check("rev_x", {21'd0, bus.topLeftX}, 506);
        check("rev_fleeing", 32'(bus.fleeing), 1);
        step(1, 4'b1111, 600, 344, 0, 0, 1);
        check("flee_x", {21'd0, bus.topLeftX}, 505);
`else
        check("noflee_dir", 32'(bus.direction), 1);
        check("noflee_x", {21'd0, bus.topLeftX}, 508);
        check("noflee_fleeing", 32'(bus.fleeing), 0);
`endif

        // Kill coincident with a frame, then respawn.
        step(1, 4'b1111, 600, 344, 1, 0, 0);
        check("kill_alive", 32'(bus.alive), 0);
        repeat (RespawnFrames - 1) step(1, 4'b1111, 600, 344, 1, 0, 0);
        check("dead_alive", 32'(bus.alive), 0);
        step(1, 4'b1111, 600, 344, 0, 0, 0);
        check("resp_alive", 32'(bus.alive), 1);
        check("resp_x", {21'd0, bus.topLeftX}, 504);
        check("resp_y", {21'd0, bus.topLeftY}, 344);
        check("resp_dir", 32'(bus.direction), 3);

        // Blocked on all sides.
        repeat (3) step(1, 4'b0000, 100, 100, 0, 0, 0);
        check("blocked_x", {21'd0, bus.topLeftX}, 504);
        check("blocked_dir", 32'(bus.direction), 3);

        // Reset while dead.
        step(0, 4'b0000, 0, 0, 0, 1, 0);
        check("died_alive", 32'(bus.alive), 0);
        do_reset();

        // Randomized traffic.
        begin
            bit flee_lvl;
            flee_lvl = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 99) == 0) flee_lvl = ~flee_lvl;
                if ($urandom_range(0, 599) == 0) do_reset();
                step($urandom_range(0, 2) == 0, 4'($urandom), 11'($urandom_range(300, 700)),
                     11'($urandom_range(200, 500)), $urandom_range(0, 149) == 0,
                     $urandom_range(0, 299) == 0, flee_lvl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_chase_ctrl.md
# enemy_chase_ctrl

Parametrised enemy movement controller for the maze playfield: one instance per enemy sprite, placed between the tile/collision logic (which supplies `free_direction`) and the enemy draw/collision objects. Picks a heading each frame, at junctions steering toward the player (CHASE) or away (FLEE), and advances a 1/64-pixel fixed-point position. Handles death and respawn after a programmable number of frames. It succeeds the single-speed alien mover with configurable speed, spawn point, respawn time and a flee mode.

## Interface
Parameters:
- INITIAL_X, 504: spawn top-left X, pixels.
- INITIAL_Y, 344: spawn top-left Y, pixels.
- SPEED, 128: step per frame in 1/64 pixel units; must be an even value in 2..1024.
- RESPAWN_FRAMES, 256: frames spent dead before respawn; range 1..2047.

Ports:
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame.
- free_direction  in  4  open paths: bit3 up, bit2 right, bit1 down, bit0 left.
- player_x, player_y  in  11 each  player top-left, unsigned pixels.
- enemy_hit  in  1  pulse: enemy killed.
- player_died  in  1  pulse: round lost, enemy removed.
- flee_req  in  1  level: player powered, enemy should flee.
- alive  out  1  enemy visible and collidable.
- fleeing  out  1  state is FLEE.
- direction  out  2  current heading: 0 up, 1 right, 2 down, 3 left.
- topLeftX, topLeftY  out  11 signed each  position = fixed-point position / 64, truncated toward zero.

## Operation
- States: CHASE, FLEE, DEAD. `alive` = (state != DEAD). `fleeing` = (state == FLEE).
- Reset: state CHASE, direction 3 (left), position INITIAL_*×64, respawn counter 0, alive 1, fleeing 0.
- All state, heading and position updates happen only on cycles with startOfFrame=1, except kills.
- Kill: enemy_hit or player_died while not DEAD → next edge state DEAD, counter 0, position frozen. This takes priority over a coincident startOfFrame, so no move occurs that frame. Kill inputs while DEAD are ignored.
- DEAD, on each startOfFrame: counter+1. When counter == RESPAWN_FRAMES-1 at startOfFrame: position ← spawn, direction ← 3, counter ← 0, state ← CHASE (or FLEE if flee_req=1).
- CHASE→FLEE on startOfFrame with flee_req=1: direction reversed (XOR 2), no move that frame. FLEE→CHASE on startOfFrame with flee_req=0: no reversal, normal move.
- Heading choice each alive frame, using sum s = popcount(free_direction):
  - s=0: heading held, no move.
  - s=1: the single open direction.
  - s=2: keep the heading if open. Otherwise take the first open direction in priority up, right, down, left, excluding the reverse of the heading.
  - s≥3: dx = |player_x[10:5] − X[10:5]|, dy likewise (6-bit block units). If dx≥dy the primary axis is X, else Y. Target side is toward the player in CHASE and away from it in FLEE; an equal coordinate counts as right/down for CHASE and as left/up for FLEE. Take the target-side direction on the primary axis if open, else the target-side direction on the other axis if open, else the first open direction in priority up, right, down, left.
- Move: the chosen heading is registered and the position is stepped by SPEED along it (SPEED>>1 in FLEE) on the same edge. Up and left subtract. Arithmetic is 32-bit signed; no clamping, because tile logic prevents leaving the maze.

## Timing
- Heading and position outputs change the edge after startOfFrame is sampled high. Latency is one cycle.
- `alive` falls one cycle after a kill pulse. On respawn, `alive` rises in the same cycle the position jumps to spawn.
- Heading logic is combinational from inputs registered elsewhere; there is no input registering inside the block.
- Asserting resetN low mid-frame or while dead returns the block to the reset values immediately.

## Configuration
- ENEMY_FLEE_EN defined: FLEE state, flee_req handling, reversal and half speed are all present.
- ENEMY_FLEE_EN undefined: flee_req is ignored, `fleeing` is tied to 0, and respawn always enters CHASE.

## Structure
- Package `enemy_pkg`: direction enum (DIR_UP=0, DIR_RIGHT, DIR_DOWN, DIR_LEFT), state enum (CHASE, FLEE, DEAD), FIXED_POINT_MULTIPLIER=64, and the reverse-direction function.
- Sub-module `enemy_dir_select`: purely combinational heading chooser. Inputs: free_direction, current heading, positions, flee flag. Output: next heading and a move-enable.

## Test plan
- Reset with defaults → topLeftX=504, Y=344, direction=3, alive=1. Hold free_direction=4'b0001 for 2 frames → topLeftX=500.
- free_direction=4'b0101, heading right, one frame → direction=1, X +2. Then free_direction=4'b1010 → no reverse; turns up, X fixed, Y −2.
- Junction 4'b1111, player at (600,344), enemy at (504,344) → right. With flee_req=1, first frame reverses with no move, next frame → left at −1 px/frame.
- enemy_hit coincident with startOfFrame → no move, alive=0 next cycle. After RESPAWN_FRAMES=4 frames → alive=1 at (504,344), direction=3.
- free_direction=0 for 3 frames → position and direction unchanged.
- Build without ENEMY_FLEE_EN, drive flee_req=1 at a junction → chases, fleeing=0.
